// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: one shift-add (mult) or restoring
// shift-subtract (div) step per clock on a shared 2*WIDTH accumulator.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0]   ZERO  = '0;
  localparam logic [2*WIDTH-1:0] ZERO2 = '0;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mag_q, hi_q, lo_q;
  logic               div_q, dz_q, neg_q, rneg_q, done_q, div_zero_q;

  logic               a_neg, b_neg, b_zero;
  logic [WIDTH-1:0]   a_mag, b_mag;

  assign a_neg  = ~op[0] & a[WIDTH-1];
  assign b_neg  = ~op[0] & b[WIDTH-1];
  assign a_mag  = a_neg ? (ZERO - a) : a;
  assign b_mag  = b_neg ? (ZERO - b) : b;
  assign b_zero = (b == ZERO);

  // Multiply: multiplier sits in the low half and shifts out LSB first.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : {1'b0, ZERO});
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: remainder in the high half, dividend/quotient bits in the low half.
  // Remainder stays below the divisor, so the borrow bit alone decides the step.
  logic [WIDTH:0]     div_tmp, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
  assign div_tmp  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff = div_tmp - {1'b0, mag_q};
  assign div_ge   = ~div_diff[WIDTH];
  assign div_next = {(div_ge ? div_diff[WIDTH-1:0] : div_tmp[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};

  assign acc_d = div_q ? div_next : mul_next;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod_fix = neg_q  ? (ZERO2 - acc_q) : acc_q;
  assign quo_fix  = neg_q  ? (ZERO - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
  assign rem_fix  = rneg_q ? (ZERO - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (op[1] && b_zero) ? FIN : RUN;
      RUN:     if (cnt_q == CW'(1)) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      mag_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_q      <= 1'b0;
      dz_q       <= 1'b0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          div_q      <= op[1];
          dz_q       <= op[1] & b_zero;
          neg_q      <= a_neg ^ b_neg;
          rneg_q     <= a_neg;
          cnt_q      <= CW'(WIDTH);
          div_zero_q <= 1'b0;
          mag_q      <= op[1] ? b_mag : a_mag;
          acc_q      <= op[1] ? {ZERO, a_mag} : {ZERO, b_mag};
        end
        RUN: begin
          cnt_q <= cnt_q - CW'(1);
          acc_q <= acc_d;
        end
        FIN: begin
          done_q <= 1'b1;
          if (dz_q)       div_zero_q   <= 1'b1;
          else if (div_q) {hi_q, lo_q} <= {rem_fix, quo_fix};
          else            {hi_q, lo_q} <= prod_fix;
        end
        default: ;
      endcase
    end
  end

  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: vector table plus random ops through a scoreboard,
// then hand-written sequences for divide-by-zero, ignored start and reset.
module tb_mult_div_unit;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset, start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  mult_div_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dz;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] hi, lo;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    longint      sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00:   begin q = sx * sy; p = q; end
      2'b01:   p = {32'h0, x} * {32'h0, y};
      2'b10:   begin q = sx / sy; r = sx % sy; p = {r[31:0], q[31:0]}; end
      default: p = {x % y, x / y};
    endcase
    e.hi = p[63:32];
    e.lo = p[31:0];
    e.dz = 1'b0;
    e.lat = 33;
    return e;
  endfunction

  // Drives one request through edge 0 and records what the scoreboard expects.
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input exp_t e);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    sb.push_back(e);
    chk("busy_after_accept", {63'h0, busy}, 64'h1);
    chk("done_one_cycle", {63'h0, done}, 64'h0);
  endtask

  task automatic finish_op(input string name);
    int   n = 0;
    logic drop = 1'b0;
    exp_t e;
    while (!done && n < 40) begin
      if (!busy) drop = 1'b1;
      tick();
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done expected done within 40 cycles", name);
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      chk({name, "_hi"}, {32'h0, hi}, {32'h0, e.hi});
      chk({name, "_lo"}, {32'h0, lo}, {32'h0, e.lo});
      chk({name, "_dz"}, {63'h0, div_zero}, {63'h0, e.dz});
      chk({name, "_lat"}, 64'(n), 64'(e.lat));
      chk({name, "_busy_held"}, {63'h0, drop}, 64'h0);
      chk({name, "_idle"}, {63'h0, busy}, 64'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[10];
    exp_t e;
    int   cnt_done;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    tbl[0] = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33};
    tbl[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33};
    tbl[2] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
    tbl[3] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
    tbl[4] = '{2'b11, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0, 33};
    tbl[5] = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 33};
    tbl[6] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33};
    tbl[7] = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33};
    tbl[8] = '{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0, 33};
    tbl[9] = '{2'b00, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b0, 33};

    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    tick();
    tick();
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_done", {63'h0, done}, 64'h0);
    chk("rst_hi", {32'h0, hi}, 64'h0);
    chk("rst_lo", {32'h0, lo}, 64'h0);
    chk("rst_dz", {63'h0, div_zero}, 64'h0);
    reset = 1'b0;
    tick();

    // Back-to-back: each start is driven in the cycle done is high.
    for (int i = 0; i < 10; i++) begin
      e = '{tbl[i].hi, tbl[i].lo, tbl[i].dz, tbl[i].lat};
      launch(tbl[i].op, tbl[i].a, tbl[i].b, e);
      finish_op($sformatf("vec%0d", i));
    end

    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom();
      rb = $urandom();
      if (ro[1] && rb == 32'h0) rb = 32'h1;
      launch(ro, ra, rb, model(ro, ra, rb));
      finish_op($sformatf("rnd%0d", i));
    end

    // Divide by zero keeps hi/lo and sets the flag after one step.
    launch(2'b01, 32'h12345678, 32'h00000100, '{32'h00000012, 32'h34567800, 1'b0, 33});
    finish_op("prior");
    launch(2'b11, 32'h00000064, 32'h00000000, '{32'h00000012, 32'h34567800, 1'b1, 1});
    finish_op("divzero");
    launch(2'b11, 32'h00000064, 32'h00000007, '{32'h00000002, 32'h0000000E, 1'b0, 33});
    chk("dz_cleared", {63'h0, div_zero}, 64'h0);
    finish_op("after_dz");

    // Second start at edge 5 must be ignored.
    op = 2'b01; a = 32'h3; b = 32'h5; start = 1'b1;
    tick();
    start = 1'b0;
    sb.push_back('{32'h0, 32'hF, 1'b0, 28});
    repeat (4) tick();
    op = 2'b00; a = 32'h7; b = 32'h9; start = 1'b1;
    tick();
    start = 1'b0;
    finish_op("ignored_start");

    // Reset at edge 10 abandons the operation.
    launch(2'b01, 32'h0000FFFF, 32'h0000FFFF, '{32'h0, 32'hFFFE0001, 1'b0, 33});
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    chk("midrst_busy", {63'h0, busy}, 64'h0);
    chk("midrst_hi", {32'h0, hi}, 64'h0);
    chk("midrst_lo", {32'h0, lo}, 64'h0);
    cnt_done = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) cnt_done++;
    end
    chk("midrst_no_done", 64'(cnt_done), 64'h0);

    // Reset wins over a simultaneous start.
    op = 2'b01; a = 32'h2; b = 32'h3; start = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    chk("rst_prio_busy", {63'h0, busy}, 64'h0);
    tick();
    chk("rst_prio_busy2", {63'h0, busy}, 64'h0);
    chk("rst_prio_done", {63'h0, done}, 64'h0);

    launch(2'b01, 32'h2, 32'h3, '{32'h0, 32'h6, 1'b0, 33});
    finish_op("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
